// File: rtl/regfile_port_arbiter.sv
// Round-robin share of the reg_file read/write ports between the
// compute sequencer (m0) and the readout/debug port (m1).
module regfile_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int WP_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wena,
  output logic              busy
);

  logic              lg_q, lg_d;
  logic              v_q, v_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              fv_q, fv_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic              g0, g1;
  logic              drop, wena, rd_iss;
  logic [DATA_W-1:0] rd_sel;

  // Grant: lone requester wins; on conflict the one not served last.
  always_comb begin
    g0 = rst_n && m0_req && (!m1_req || lg_q);
    g1 = rst_n && m1_req && !g0;
  end

  // Issue-stage decode, write protection and read-data forwarding.
  always_comb begin
    drop   = v_q && id_q && we_q && (int'(a_q) < WP_LIMIT);
    wena   = v_q && we_q && !drop;
    rd_iss = v_q && !we_q;
    rd_sel = (fv_q && fa_q == a_q) ? fd_q : rf_rdata;
  end

  // Next state: load the granted op, track the committing write,
  // steer read data back to the master that issued it.
  always_comb begin
    lg_d  = lg_q;
    v_d   = g0 || g1;
    id_d  = id_q;
    we_d  = we_q;
    a_d   = a_q;
    wd_d  = wd_q;
    unique case (1'b1)
      g0: begin
        lg_d = 1'b0;
        id_d = 1'b0;
        we_d = m0_we;
        a_d  = m0_addr;
        wd_d = m0_wdata;
      end
      g1: begin
        lg_d = 1'b1;
        id_d = 1'b1;
        we_d = m1_we;
        a_d  = m1_addr;
        wd_d = m1_wdata;
      end
      default: ;
    endcase
    fv_d  = wena;
    fa_d  = a_q;
    fd_d  = wd_q;
    rv0_d = rd_iss && !id_q;
    rv1_d = rd_iss && id_q;
    rd0_d = rv0_d ? rd_sel : rd0_q;
    rd1_d = rv1_d ? rd_sel : rd1_q;
  end

  // State registers; reset discards the in-flight op and read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg_q  <= 1'b1;
      v_q   <= 1'b0;
      id_q  <= 1'b0;
      we_q  <= 1'b0;
      a_q   <= '0;
      wd_q  <= '0;
      fv_q  <= 1'b0;
      fa_q  <= '0;
      fd_q  <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      lg_q  <= lg_d;
      v_q   <= v_d;
      id_q  <= id_d;
      we_q  <= we_d;
      a_q   <= a_d;
      wd_q  <= wd_d;
      fv_q  <= fv_d;
      fa_q  <= fa_d;
      fd_q  <= fd_d;
      rv0_q <= rv0_d;
      rv1_q <= rv1_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign m1_err    = drop;
  assign rf_raddr  = a_q;
  assign rf_waddr  = a_q;
  assign rf_wdata  = wd_q;
  assign rf_wena   = wena;
  assign busy      = v_q;

endmodule
